// File: rtl/dcache_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dcache_pkg                                                 |
// | Brief    : Shared types, widths and helpers for the L1 data cache.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    // Widest tag the tag array holds; narrower tags are zero-extended into it.
    localparam int TAG_MAX_W  = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } dc_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } dc_tag_t;

    function automatic logic [WORD_W-1:0] line_word(
        input logic [LINE_W-1:0]     line,
        input logic [WORD_SEL_W-1:0] sel
    );
        return line[{sel, 5'b0} +: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dcache_sram                                                |
// | Brief    : Tag/data arrays: indexed read, line fill, word store.      |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_MAX_W-1:0]  tag_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic                  fill_i,
    input  logic [TAG_MAX_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0]     fill_line_i,
    input  logic                  store_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     store_data_i
);

    dc_tag_t           entry_q [NUM_LINES];
    logic [LINE_W-1:0] data_q  [NUM_LINES];
    dc_tag_t           entry_d;
    logic [LINE_W-1:0] line_d;
    logic              w_wr_en;

    assign valid_o = entry_q[idx_i].valid;
    assign dirty_o = entry_q[idx_i].dirty;
    assign tag_o   = entry_q[idx_i].tag;
    assign line_o  = data_q[idx_i];
    assign w_wr_en = (fill_i || store_i) && !rst_i;

    always_comb begin
        entry_d = entry_q[idx_i];
        line_d  = data_q[idx_i];
        if (fill_i) begin
            entry_d.valid = 1'b1;
            entry_d.dirty = 1'b0;
            entry_d.tag   = fill_tag_i;
            line_d        = fill_line_i;
        end else if (store_i) begin
            entry_d.dirty = 1'b1;
            line_d[{word_sel_i, 5'b0} +: WORD_W] = store_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            entry_q[idx_i] <= entry_d;
        end
    end

    // Data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            data_q[idx_i] <= line_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dcache_controller                                          |
// | Brief    : Direct-mapped write-back/write-allocate L1 D-cache for the |
// |            MEM stage. Optional hit/miss counters: DCACHE_STATS_EN.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    dc_state_e state_q, state_d;
    logic      mem_enable_q, mem_enable_d;
    logic      mem_write_q, mem_write_d;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [TAG_MAX_W-1:0]  w_tag_ext;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic                  w_req, w_store, w_load, w_idle, w_hit;
    logic                  w_fill, w_store_hit;
    logic                  w_line_valid, w_line_dirty;
    logic [TAG_MAX_W-1:0]  w_line_tag;
    logic [LINE_W-1:0]     w_line;
    logic                  w_unused;

    assign w_idx      = cpu_addr_i[OFFSET_W +: IDX_W];
    assign w_tag      = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_tag_ext  = TAG_MAX_W'(w_tag);
    assign w_word_sel = cpu_addr_i[2 +: WORD_SEL_W];
    assign w_unused   = ^cpu_addr_i[1:0];

    // A simultaneous read and write request is a store.
    assign w_req       = cpu_MemRead_i || cpu_MemWrite_i;
    assign w_store     = cpu_MemWrite_i;
    assign w_load      = cpu_MemRead_i && !cpu_MemWrite_i;
    assign w_idle      = (state_q == ST_IDLE);
    assign w_hit       = w_line_valid && (w_line_tag == w_tag_ext);
    assign w_fill      = (state_q == ST_ALLOCATE) && mem_ack_i;
    assign w_store_hit = w_idle && w_store && w_hit;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .idx_i        (w_idx),
        .valid_o      (w_line_valid),
        .dirty_o      (w_line_dirty),
        .tag_o        (w_line_tag),
        .line_o       (w_line),
        .fill_i       (w_fill),
        .fill_tag_i   (w_tag_ext),
        .fill_line_i  (mem_data_i),
        .store_i      (w_store_hit),
        .word_sel_i   (w_word_sel),
        .store_data_i (cpu_data_i)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    state_d = (w_line_valid && w_line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) state_d = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ack_i) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        mem_enable_d = (state_d != ST_IDLE);
        mem_write_d  = (state_d == ST_WRITEBACK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // The miss is flagged in the same cycle the request first appears.
    assign cpu_stall_o  = !w_idle || (w_req && !w_hit);
    assign cpu_data_o   = (w_idle && w_load && w_hit) ? line_word(w_line, w_word_sel) : 32'd0;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = (state_q == ST_WRITEBACK) ? w_line : '0;

    always_comb begin
        case (state_q)
            ST_WRITEBACK: mem_addr_o = {w_line_tag[TAG_W-1:0], w_idx, {OFFSET_W{1'b0}}};
            ST_ALLOCATE:  mem_addr_o = {w_tag, w_idx, {OFFSET_W{1'b0}}};
            default:      mem_addr_o = '0;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        refill_q, refill_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // refill_q marks the re-hit that completes a fill so it is not counted.
    always_comb begin
        refill_d   = w_fill;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (w_idle && w_req && w_hit && !refill_q && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (w_idle && w_req && !w_hit && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dcache_controller                                       |
// | Brief    : Random + directed bench against a flat-memory reference.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i, cpu_data_i;
    logic         cpu_MemRead_i, cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i, model_ack, manual_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    assign mem_ack_i = model_ack | manual_ack;

    dcache_controller u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: architectural word memory (last store wins) over backing memory.
    logic [31:0]  golden  [logic [31:0]];
    logic [255:0] memline [logic [31:0]];
    // Cache occupancy, used only to predict miss cost and victims.
    logic         c_valid [16];
    logic         c_dirty [16];
    logic [22:0]  c_tag   [16];
    int           m_hits, m_misses;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0]  la;
        logic [255:0] l;
        la = {a[31:5], 5'b0};
        if (memline.exists(la)) begin
            l = memline[la];
            return l[{a[4:2], 5'b0} +: 32];
        end
        return pattern({a[31:2], 2'b0});
    endfunction

    function automatic logic [31:0] cur_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b0};
        return golden.exists(wa) ? golden[wa] : mem_word(wa);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] golden_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = cur_word(la + 32'(w * 4));
        return l;
    endfunction

    // Off-chip memory: acks after `lat` enabled cycles, one-cycle pulse.
    int          lat = 10;
    int          lat_cnt = 0;
    bit          model_en = 1'b1;
    logic        ops_we   [$];
    logic [31:0] ops_addr [$];

    always @(negedge clk_i) begin
        if (model_ack) lat_cnt = 0;
        model_ack = 1'b0;
        if (!model_en || rst_i || !mem_enable_o) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt == lat) begin
                model_ack = 1'b1;
                ops_we.push_back(mem_write_o);
                ops_addr.push_back(mem_addr_o);
                if (mem_write_o) begin
                    check("wb_data", mem_data_o, golden_line(mem_addr_o));
                    memline[mem_addr_o] = mem_data_o;
                end else begin
                    mem_data_i = mem_line(mem_addr_o);
                end
            end
        end
    end

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            c_valid[i] = 1'b0;
            c_dirty[i] = 1'b0;
            c_tag[i]   = '0;
        end
        golden.delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Called #1 after a posedge; returns #1 after the completing posedge.
    task automatic do_access(input logic [31:0] addr, input bit st, input logic [31:0] wdata);
        logic [3:0]  idx;
        logic [22:0] tg;
        logic [31:0] victim;
        bit          hit, dirty_victim;
        int          stalls, n_exp, exp_stalls, limit;
        idx          = addr[8:5];
        tg           = addr[31:9];
        hit          = c_valid[idx] && (c_tag[idx] == tg);
        dirty_victim = !hit && c_valid[idx] && c_dirty[idx];
        victim       = {c_tag[idx], idx, 5'b0};
        n_exp        = hit ? 0 : (dirty_victim ? 2 : 1);
        exp_stalls   = hit ? 0 : (dirty_victim ? 2 * lat + 1 : lat + 1);
        limit        = 4 * lat + 20;
        stalls       = 0;
        ops_we.delete();
        ops_addr.delete();
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        cpu_MemWrite_i = st;
        cpu_MemRead_i  = st ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            @(negedge clk_i);
            if (!cpu_stall_o || stalls > limit) break;
            stalls++;
            if (stalls == 1) check("miss_data", cpu_data_o, 32'd0);
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("rd_data", cpu_data_o, st ? 32'd0 : cur_word(addr));
        check("mem_ops", 32'(ops_we.size()), 32'(n_exp));
        if (ops_we.size() == n_exp && n_exp > 0) begin
            if (dirty_victim) begin
                check("wb_we", ops_we[0], 1'b1);
                check("wb_addr", ops_addr[0], victim);
            end
            check("fill_we", ops_we[n_exp-1], 1'b0);
            check("fill_addr", ops_addr[n_exp-1], {addr[31:5], 5'b0});
        end
        @(posedge clk_i);
        #1;
        if (hit) m_hits++;
        else     m_misses++;
        if (!hit) begin
            c_valid[idx] = 1'b1;
            c_dirty[idx] = 1'b0;
            c_tag[idx]   = tg;
        end
        if (st) begin
            golden[{addr[31:2], 2'b0}] = wdata;
            c_dirty[idx] = 1'b1;
        end
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        int waited;
        rst_i          = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        model_ack      = 1'b0;
        manual_ack     = 1'b0;
        clear_models();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_data", cpu_data_o, 32'd0);
        check("rst_maddr", mem_addr_o, 32'd0);
        @(posedge clk_i);
        #1;

        // Directed sequence at latency 10.
        do_access(32'h0000_0040, 1'b0, 32'd0);
        do_access(32'h0000_0044, 1'b1, 32'hDEAD_BEEF);
        do_access(32'h0000_0044, 1'b0, 32'd0);
        do_access(32'h0000_0240, 1'b0, 32'd0);
        do_access(32'h0000_0088, 1'b1, 32'h1234_5678);
        do_access(32'h0000_0088, 1'b0, 32'd0);
        do_access(32'h0000_0488, 1'b0, 32'd0);

        // Reset while a fill is outstanding.
        model_en      = 1'b0;
        cpu_addr_i    = 32'h0000_00E0;
        cpu_MemRead_i = 1'b1;
        waited        = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!mem_enable_o && waited < 20);
        check("abort_en", mem_enable_o, 1'b1);
        check("abort_we", mem_write_o, 1'b0);
        check("abort_addr", mem_addr_o, 32'h0000_00E0);
        @(posedge clk_i);
        #1;
        rst_i         = 1'b1;
        cpu_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_en_drop", mem_enable_o, 1'b0);
        @(posedge clk_i);
        #1 manual_ack = 1'b1;
        @(posedge clk_i);
        #1 manual_ack = 1'b0;
        @(negedge clk_i);
        check("late_ack_en", mem_enable_o, 1'b0);
        check("late_ack_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        clear_models();
        model_en = 1'b1;
        do_access(32'h0000_00E0, 1'b0, 32'd0);

        // Random traffic over a few sets and tags to force conflicts.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if (n % 50 == 0) lat = $urandom_range(1, 4);
            a = {1'($urandom_range(0, 1)), 20'd0, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            do_access(a, 1'($urandom_range(0, 1)), $urandom);
        end

`ifdef DCACHE_STATS_EN
        @(negedge clk_i);
        check("hit_cnt", hit_cnt_o, 32'(m_hits));
        check("miss_cnt", miss_cnt_o, 32'(m_misses));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Responder for the MEM-stage memory request. It receives MemRead/MemWrite, the ALU address and the RS2 store data from the EX/MEM register.
- Answers hits in the same cycle and asserts cpu_stall_o, which freezes the pipeline registers on a miss.
- Direct-mapped, write-back, write-allocate L1 data cache in front of a 256-bit-line off-chip data memory with an enable/ack handshake.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two); index width IDX_W = log2(NUM_LINES).
- LINE_W, 256, line width in bits; fixed 32 bytes, 8 words.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_addr_i  in  32  byte address from the EX/MEM ALU result
- cpu_data_i  in  32  store data (RS2)
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  stall to all pipeline registers
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  writeback line
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = writeback, 0 = fill
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Address split: offset [4:0], word select [4:2], index [4+IDX_W:5], tag [31:5+IDX_W] (23 bits at default).
- Per-line storage: valid, dirty, tag, 256-bit data.
- req = cpu_MemRead_i | cpu_MemWrite_i.
- hit = valid[idx] & (tag[idx] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, req & hit:
  - cpu_stall_o = 0.
  - Load: cpu_data_o = selected word, combinational, same cycle.
  - Store: at posedge the selected word is written and dirty is set.
- IDLE, req & ~hit:
  - cpu_stall_o = 1 combinationally, same cycle.
  - Next state is WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {stored tag, idx, 5'b0}; mem_data_o = stored line.
  - Hold until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {addr tag, idx, 5'b0}.
  - On mem_ack_i: line = mem_data_i, valid = 1, dirty = 0, tag updated; go to IDLE.
- After a fill, the request is still presented because the pipeline is stalled. It now hits in IDLE and completes with stall low; a store merges its word on that hit cycle.
- cpu_stall_o = 1 in every non-IDLE state.
- mem_enable_o and mem_write_o are 0 in IDLE; mem_addr_o and mem_data_o are don't-care while enable is low, and are driven to 0 there.
- cpu_data_o = 0 when there is no load hit.
- Both MemRead and MemWrite high is treated as a store.
- mem_ack_i in IDLE is ignored.
- Reset:
  - All valid and dirty bits cleared; state = IDLE.
  - cpu_stall_o, mem_enable_o, mem_write_o = 0; cpu_data_o = 0.
  - Reset mid-transaction abandons it: enable drops in the cycle after reset, and no line is written.
- Address inputs must stay stable while stalled; the controller does not latch them.
- Miss penalty: memory latency + 1 cycle for a clean miss; twice the memory latency + 1 for a dirty miss.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], saturating, cleared by rst_i.
  - hit_cnt_o increments on each completing hit cycle, excluding the post-fill re-hit.
  - miss_cnt_o increments on each IDLE→WRITEBACK/ALLOCATE transition.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - State enum (IDLE, WRITEBACK, ALLOCATE).
  - OFFSET_W = 5, WORD_SEL_W = 3, LINE_W.
  - Tag-entry typedef {valid, dirty, tag}.
- Sub-module dcache_sram:
  - Tag and data arrays with index-addressed read, full-line write and 32-bit word write with dirty set.
  - Controller FSM and hit logic stay in dcache_controller.

Test Plan:
- Reset, then load from 0x0000_0040 (memory line filled with pattern) → stall high for 10+1 cycles with memory latency 10; one ALLOCATE request with mem_addr_o = 0x40; then cpu_data_o = word 0, stall 0.
- Store 0xDEADBEEF to 0x44 after the previous fill → no stall; then a load from 0x44 returns 0xDEADBEEF in the same cycle; the line is marked dirty.
- Load from 0x0000_0240 (same index 2, different tag) → WRITEBACK to 0x40 with mem_data_o word 1 = 0xDEADBEEF; then ALLOCATE at 0x240; total stall 2×latency + 1.
- Store miss to 0x88 (clean) → ALLOCATE only, no writeback; a following load from 0x88 returns the stored value and the line is dirty.
- Assert rst_i during ALLOCATE → mem_enable_o = 0 in the next cycle; a late mem_ack_i is ignored; a load from the same address misses again.
- With DCACHE_STATS_EN: sequence of 3 misses and 5 hits → miss_cnt_o = 3, hit_cnt_o = 5.
